// File: rtl/mod_inv_if.sv
// Handshake bundle for the Montgomery word-inverse block.
//   go         : start request, sampled on the rising clock edge
//   n          : modulus; only the low WWIDTH bits are used
//   modulo_inv : registered result, -n0^-1 mod 2^WWIDTH
//   valid      : registered one-cycle result-ready pulse
// master = requester side, slave = mod_inv side.
interface mod_inv_if #(
  parameter int NWIDTH = 4096,
  parameter int WWIDTH = 64
);
  logic              go;
  logic [NWIDTH-1:0] n;
  logic [WWIDTH-1:0] modulo_inv;
  logic              valid;

  modport master (output go, output n, input modulo_inv, input valid);
  modport slave  (input go, input n, output modulo_inv, output valid);
endinterface

// File: rtl/mod_inv.sv
// Computes the Montgomery constant -n0^-1 mod 2^WWIDTH with one bit of
// Hensel lifting per clock. Fixed latency: valid pulses WWIDTH-1 edges after
// the edge that accepted go. Even n0 is not rejected; it simply runs the same
// sequence and yields whatever the iteration produces.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-low reset
//   bus   : mod_inv_if slave modport (go, n in; modulo_inv, valid out)
module mod_inv #(
  parameter int NWIDTH = 4096,
  parameter int WWIDTH = 64
) (
  input  logic      clk,
  input  logic      reset,
  mod_inv_if.slave  bus
);

  localparam int IW = (WWIDTH > 1) ? $clog2(WWIDTH) : 1;
  localparam logic [IW-1:0] LAST_I = IW'(WWIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_reg, state_next;
  logic [WWIDTH-1:0] n0_reg, n0_next;
  logic [WWIDTH-1:0] inv_reg, inv_next;
  logic [WWIDTH-1:0] p_reg, p_next;
  logic [IW-1:0]     i_reg, i_next;
  logic [WWIDTH-1:0] result_reg, result_next;
  logic              valid_reg, valid_next;

  // Upper modulus bits are intentionally ignored.
  generate
    if (NWIDTH > WWIDTH) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^bus.n[NWIDTH-1:WWIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      n0_reg     <= '0;
      inv_reg    <= '0;
      p_reg      <= '0;
      i_reg      <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      n0_reg     <= n0_next;
      inv_reg    <= inv_next;
      p_reg      <= p_next;
      i_reg      <= i_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
    end
  end

  // Invariant during RUN: p == n0 * inv (mod 2^WWIDTH) and p == 1 (mod 2^i).
  // If bit i of p is set, adding bit i to inv (p += n0 << i) clears it,
  // because n0 is odd. After the last step inv == n0^-1.
  always_comb begin
    state_next  = state_reg;
    n0_next     = n0_reg;
    inv_next    = inv_reg;
    p_next      = p_reg;
    i_next      = i_reg;
    result_next = result_reg;
    valid_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.go) begin
          n0_next    = bus.n[WWIDTH-1:0];
          inv_next   = WWIDTH'(1);
          p_next     = bus.n[WWIDTH-1:0];
          i_next     = IW'(1);
          state_next = RUN;
        end
      end
      RUN: begin
        if (p_reg[i_reg]) begin
          inv_next[i_reg] = 1'b1;
          p_next          = p_reg + (n0_reg << i_reg);
        end
        i_next = i_reg + IW'(1);
        if (i_reg == LAST_I) begin
          // Negate the finished inverse to get the Montgomery constant.
          result_next = WWIDTH'(0) - inv_next;
          valid_next  = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.modulo_inv = result_reg;
  assign bus.valid      = valid_reg;

endmodule

// File: tb/tb_mod_inv.sv
// Scoreboard bench for mod_inv: stimulus pushes expected results (value and
// arrival cycle) into a queue; a monitor pops and compares on every valid.
module tb_mod_inv;

  localparam int NW = 4096;
  localparam int WW = 64;
  localparam int LAT = WW - 1;

  typedef struct {
    logic [63:0] n0;
    logic [63:0] exp;
    bit          has_exp;
    int          cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;
  exp_t sb[$];
  logic [63:0] last_exp;

  mod_inv_if #(.NWIDTH(NW), .WWIDTH(WW)) bus ();

  mod_inv #(.NWIDTH(NW), .WWIDTH(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  // Issue one go pulse; the edge after this negedge is the start edge.
  task automatic start(input logic [NW-1:0] nv, input logic [63:0] exp,
                       input bit has_exp);
    exp_t e;
    @(negedge clk);
    bus.n  = nv;
    bus.go = 1'b1;
    e.n0 = nv[63:0];
    e.exp = exp;
    e.has_exp = has_exp;
    e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d pending results required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every valid must match the head of the scoreboard in cycle and value.
  initial begin
    exp_t e;
    logic [63:0] prod;
    forever begin
      @(negedge clk);
      if (sb.size() != 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_valid: got no pulse required one at cycle %0d", e.cyc);
      end
      if (bus.valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got pulse at cycle %0d required none", cyc);
        end else begin
          e = sb.pop_front();
          $display("[TB] result n0=0x%h modulo_inv=0x%h cycle=%0d", e.n0, bus.modulo_inv, cyc);
          check("latency", 64'(cyc), 64'(e.cyc));
          if (e.has_exp) begin
            check("value", bus.modulo_inv, e.exp);
            last_exp = e.exp;
          end
          if (e.n0[0]) begin
            prod = e.n0 * bus.modulo_inv;
            check("product", prod, 64'hFFFF_FFFF_FFFF_FFFF);
          end
        end
      end
    end
  end

  initial begin
    logic [NW-1:0] nv;
    int s;
    tests = 0;
    fails = 0;
    last_exp = '0;
    reset = 1'b0;
    bus.go = 1'b1;          // go during reset must be ignored
    bus.n = NW'(3);
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(bus.valid), 64'd0);
    check("reset_inv", bus.modulo_inv, 64'd0);
    bus.go = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", 64'(bus.valid), 64'd0);

    // Directed vectors
    start(NW'(77), 64'd0, 1'b0);
    wait_idle();
    start(NW'(3), 64'h5555_5555_5555_5555, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk);
    check("hold", bus.modulo_inv, last_exp);
    start(NW'(1), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_idle();
    nv = '1;                // n0 all ones, upper bits set
    start(nv, 64'h0000_0000_0000_0001, 1'b1);
    wait_idle();
    start(NW'(2), 64'h0000_0000_0000_0001, 1'b1);   // even n0
    wait_idle();
    start(NW'(0), 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);   // even n0
    wait_idle();

    // go and n change mid-run: single result for the original n
    start(NW'(3), 64'h5555_5555_5555_5555, 1'b1);
    repeat (8) @(negedge clk);
    bus.go = 1'b1;
    bus.n  = NW'(5);
    @(negedge clk);
    bus.go = 1'b0;
    wait_idle();
    repeat (70) @(negedge clk);   // monitor flags any extra pulse

    // Reset mid-run: abort, outputs cleared, clean restart
    start(NW'(7), 64'd0, 1'b0);
    repeat (18) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    check("abort_valid", 64'(bus.valid), 64'd0);
    check("abort_inv", bus.modulo_inv, 64'd0);
    repeat (70) @(negedge clk);
    start(NW'(3), 64'h5555_5555_5555_5555, 1'b1);
    wait_idle();

    // go held high for 200 cycles: starts every 64 edges
    @(negedge clk);
    bus.n  = NW'(3);
    bus.go = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.n0 = 64'd3;
      e.exp = 64'h5555_5555_5555_5555;
      e.has_exp = 1'b1;
      e.cyc = s + LAT + 64 * k;
      sb.push_back(e);
    end
    repeat (200) @(negedge clk);
    bus.go = 1'b0;
    wait_idle();
    repeat (70) @(negedge clk);

    check("drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mod_inv.md
MOD_INV -- requirements
Module: modInv

Interface
REQ-001 Parameter NWIDTH, default 4096, is the width of the modulus input n.
REQ-002 Parameter WWIDTH, default 64, is the word width of the inverse, i.e. the Montgomery radix exponent.
REQ-003 Port clk  input  1  is the single clock; all logic is on the rising edge.
REQ-004 Port reset  input  1  is the synchronous, active-low reset; it is sampled only on the rising clk edge and has effect when 0.
REQ-005 Port go  input  1  is the start request, sampled at the rising edge.
REQ-006 Port n  input  NWIDTH  is the modulus; only n[WWIDTH-1:0] (n0) is used.
REQ-007 Port modulo_inv  output  WWIDTH  is the result, registered: -n0^-1 mod 2^WWIDTH.
REQ-008 Port valid  output  1  is a one-cycle result-ready pulse, registered.

Function
REQ-009 The block SHALL compute modulo_inv such that (n0 * modulo_inv) mod 2^WWIDTH = 2^WWIDTH-1, for odd n0.
REQ-010 The state machine SHALL have two states, IDLE and RUN.
REQ-011 In IDLE with go=1, the block SHALL load n0 into a held register, inv<=1, p<=n0, i<=1, and go to RUN.
REQ-012 In IDLE with go=0, the block SHALL hold all registers.
REQ-013 In RUN, each cycle SHALL do: if p[i]=1 then inv[i]<=1 and p<=p+(n0<<i) mod 2^WWIDTH; then i<=i+1.
REQ-014 When i=WWIDTH-1, the RUN step SHALL additionally load modulo_inv <= (2^WWIDTH - inv_next) mod 2^WWIDTH, set valid<=1, and return to IDLE.
REQ-015 Latency SHALL be fixed: valid is high during exactly one cycle, after the (WWIDTH-1)th rising edge following the edge that sampled go (63 edges by default).
REQ-016 valid SHALL return to 0 on the following edge, unconditionally.
REQ-017 go asserted while in RUN SHALL be ignored and SHALL NOT restart or extend the computation.
REQ-018 go held high continuously SHALL start a new computation on the edge at which the block is in IDLE, i.e. the same edge valid rises is not a start edge.
REQ-019 n SHALL be sampled only at the start edge; later changes of n SHALL NOT affect the running result.
REQ-020 modulo_inv SHALL hold its last value until the next completion.
REQ-021 Even n0 (no inverse) SHALL NOT be detected; the block SHALL run the same sequence with the same latency, and the output value is the deterministic result of REQ-013/014.
REQ-022 All additions SHALL be truncated to WWIDTH bits; i SHALL be a counter of ceil(log2(WWIDTH)) bits.

Reset
REQ-023 With reset=0 at a rising edge, the block SHALL go to IDLE and clear modulo_inv, valid, inv, p, i and the held n0 to 0.
REQ-024 Reset asserted mid-RUN SHALL abort the computation with no valid pulse; a later go SHALL restart cleanly.
REQ-025 go SHALL be ignored while reset=0.

Verification
REQ-026 Scenario: n=77 -> after exactly 63 edges, valid pulses once, and (77*modulo_inv) mod 2^64 = 0xFFFFFFFFFFFFFFFF.
REQ-027 Scenario: n=3 -> modulo_inv=0x5555555555555555; n=1 -> modulo_inv=0xFFFFFFFFFFFFFFFF.
REQ-028 Scenario: n0=0xFFFFFFFFFFFFFFFF with upper n bits nonzero -> modulo_inv=0x0000000000000001 (upper bits are ignored).
REQ-029 Scenario: go pulses at cycle 10 of a run, plus n changed mid-run -> a single valid pulse with the result of the originally sampled n.
REQ-030 Scenario: reset=0 at cycle 20 of a run -> no valid pulse and outputs are 0; a new go with n=3 -> 0x5555555555555555 after 63 edges.
REQ-031 Scenario: go held high for 200 cycles with n=3 -> valid pulses spaced exactly 64 cycles apart, each pulse 1 cycle wide.
